// File: rtl/priority_encoder_queue.sv
// Pending-request register with a registered priority encoder that presents one
// index at a time over a valid/ready output.
module priority_encoder_queue #(
   parameter  int N = 8,
   localparam int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [N-1:0] req,
   input  logic         msb_first,
   input  logic         out_ready,
   output logic         out_valid,
   output logic [W-1:0] code,
   output logic [N-1:0] pending,
   output logic         collision
);

   // Handshake: an index is transferred on every rising edge where out_valid and
   // out_ready are both 1; code and out_valid are frozen while out_ready is 0.

   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

   state_t       state_q;
   logic [N-1:0] pending_q, pending_d;
   logic [W-1:0] code_q;
   logic         out_valid_q;
   logic         collision_q, collision_d;
   logic         accept;
   logic [N-1:0] served;
   logic [N-1:0] captured;
   logic [N-1:0] remaining;

   function automatic logic [W-1:0] pick(input logic [N-1:0] v, input logic hi);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < N; i++) begin
         if (hi) begin
            if (v[i]) r = W'(i);
         end else if (v[N-1-i]) begin
            r = W'(N-1-i);
         end
      end
      return r;
   endfunction

   always_comb begin
      accept = out_valid_q & out_ready;
      served = '0;
      if (accept) served[code_q] = 1'b1;
      captured    = en ? req : '0;
      // Selection only ever looks at the registered set, never same-cycle req.
      remaining   = pending_q & ~served;
      pending_d   = remaining | captured;
      collision_d = |(captured & remaining);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         pending_q   <= '0;
         code_q      <= '0;
         out_valid_q <= 1'b0;
         collision_q <= 1'b0;
      end else begin
         pending_q   <= pending_d;
         collision_q <= collision_d;
         case (state_q)
            IDLE: begin
               if (|pending_q) begin
                  code_q      <= pick(pending_q, msb_first);
                  out_valid_q <= 1'b1;
                  state_q     <= HOLD;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  if (|remaining) begin
                     code_q <= pick(remaining, msb_first);
                  end else begin
                     code_q      <= '0;
                     out_valid_q <= 1'b0;
                     state_q     <= IDLE;
                  end
               end
            end
            default: begin
               state_q     <= IDLE;
               code_q      <= '0;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign code      = code_q;
   assign pending   = pending_q;
   assign collision = collision_q;

endmodule

// File: tb/tb_priority_encoder_queue.sv
// Directed scenarios plus random traffic for priority_encoder_queue, compared each
// cycle against a set-based reference model of the pending queue.
module tb_priority_encoder_queue;

   localparam int N = 8;
   localparam int W = 3;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         en = 1'b0;
   logic [N-1:0] req = '0;
   logic         msb_first = 1'b1;
   logic         out_ready = 1'b0;
   logic         out_valid;
   logic [W-1:0] code;
   logic [N-1:0] pending;
   logic         collision;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state: set of pending indices plus the presented index
   bit           m_set[N];
   bit           m_valid;
   int           m_code;
   bit           m_coll;

   priority_encoder_queue #(.N(N)) dut (
      .clk(clk), .rst(rst), .en(en), .req(req), .msb_first(msb_first),
      .out_ready(out_ready), .out_valid(out_valid), .code(code),
      .pending(pending), .collision(collision)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int model_pick(input bit s[N], input bit hi);
      int r;
      r = -1;
      for (int i = 0; i < N; i++)
         if (s[i] && (r < 0 || hi)) r = i;
      return r;
   endfunction

   function automatic logic [N-1:0] model_mask();
      logic [N-1:0] m;
      m = '0;
      for (int i = 0; i < N; i++) m += m_set[i] ? (N'(1) << i) : '0;
      return m;
   endfunction

   task automatic model_edge(input bit r, input bit e, input logic [N-1:0] rq,
                             input bit hi, input bit rdy);
      bit rem[N];
      int nxt;
      if (r) begin
         foreach (m_set[i]) m_set[i] = 0;
         m_valid = 0; m_code = 0; m_coll = 0;
         return;
      end
      foreach (m_set[i]) rem[i] = m_set[i] && !(m_valid && rdy && i == m_code);
      m_coll = 0;
      for (int i = 0; i < N; i++)
         if (e && rq[i] && rem[i]) m_coll = 1;
      if (!m_valid) begin
         nxt = model_pick(m_set, hi);
         if (nxt >= 0) begin m_valid = 1; m_code = nxt; end
      end else if (rdy) begin
         nxt = model_pick(rem, hi);
         if (nxt >= 0) m_code = nxt;
         else begin m_valid = 0; m_code = 0; end
      end
      foreach (m_set[i]) m_set[i] = rem[i] || (e && rq[i]);
   endtask

   // drive one cycle, clock it, then compare every output to the model
   task automatic cycle(input bit r, input bit e, input logic [N-1:0] rq,
                        input bit hi, input bit rdy);
      rst = r; en = e; req = rq; msb_first = hi; out_ready = rdy;
      @(posedge clk);
      model_edge(r, e, rq, hi, rdy);
      #1;
      check_eq("out_valid", 32'(out_valid), 32'(m_valid));
      check_eq("code", 32'(code), 32'(m_code));
      check_eq("pending", 32'(pending), 32'(model_mask()));
      check_eq("collision", 32'(collision), 32'(m_coll));
   endtask

   initial begin
      foreach (m_set[i]) m_set[i] = 0;
      m_valid = 0; m_code = 0; m_coll = 0;

      cycle(1, 1, 8'hFF, 1, 1);
      check_eq("reset_pending", 32'(pending), 32'h0);
      check_eq("reset_valid", 32'(out_valid), 32'h0);

      // single request
      cycle(0, 1, 8'h80, 1, 1);
      check_eq("single_pend", 32'(pending), 32'h80);
      check_eq("single_latency", 32'(out_valid), 32'h0);
      cycle(0, 0, 8'h00, 1, 1);
      check_eq("single_code", 32'(code), 32'd7);
      cycle(0, 0, 8'h00, 1, 1);
      check_eq("single_drain", 32'({out_valid, pending}), 32'h0);

      // ordering, both priority modes
      cycle(0, 1, 8'b0010_0101, 1, 1);
      cycle(0, 0, 8'h00, 1, 1); check_eq("msb_code0", 32'(code), 32'd5);
      cycle(0, 0, 8'h00, 1, 1); check_eq("msb_code1", 32'(code), 32'd2);
      cycle(0, 0, 8'h00, 1, 1); check_eq("msb_code2", 32'(code), 32'd0);
      cycle(0, 0, 8'h00, 1, 1); check_eq("msb_done", 32'(out_valid), 32'h0);
      cycle(0, 1, 8'b0010_0101, 0, 1);
      cycle(0, 0, 8'h00, 0, 1); check_eq("lsb_code0", 32'(code), 32'd0);
      cycle(0, 0, 8'h00, 0, 1); check_eq("lsb_code1", 32'(code), 32'd2);
      cycle(0, 0, 8'h00, 0, 1); check_eq("lsb_code2", 32'(code), 32'd5);
      cycle(0, 0, 8'h00, 0, 1); check_eq("lsb_done", 32'(out_valid), 32'h0);

      // hold stability under stall
      cycle(0, 1, 8'h04, 1, 0);
      cycle(0, 0, 8'h00, 1, 0); check_eq("hold_code", 32'(code), 32'd2);
      cycle(0, 1, 8'h80, 0, 0); check_eq("hold_stall0", 32'(code), 32'd2);
      cycle(0, 0, 8'h00, 1, 0); check_eq("hold_stall1", 32'(code), 32'd2);
      cycle(0, 0, 8'h00, 0, 0); check_eq("hold_stall2", 32'(code), 32'd2);
      cycle(0, 0, 8'h00, 1, 1); check_eq("hold_next", 32'(code), 32'd7);
      cycle(0, 0, 8'h00, 1, 1);

      // enable gating
      for (int i = 0; i < 5; i++) begin
         cycle(0, 0, 8'hFF, 1, 1);
         check_eq("gate", 32'({pending, out_valid, collision}), 32'h0);
      end

      // collision and re-queue
      cycle(0, 1, 8'h08, 1, 0);
      cycle(0, 0, 8'h00, 1, 0); check_eq("coll_code", 32'(code), 32'd3);
      cycle(0, 1, 8'h08, 1, 0); check_eq("coll_pulse", 32'(collision), 32'h1);
      cycle(0, 1, 8'h08, 1, 1);
      check_eq("requeue_pend", 32'(pending), 32'h08);
      check_eq("requeue_coll", 32'(collision), 32'h0);
      cycle(0, 0, 8'h00, 1, 1); check_eq("requeue_code", 32'({out_valid, code}), 32'h0B);
      cycle(0, 0, 8'h00, 1, 1);

      // reset mid-operation
      cycle(0, 1, 8'h0F, 1, 0);
      cycle(0, 0, 8'h00, 1, 0); check_eq("mid_hold", 32'(out_valid), 32'h1);
      cycle(1, 1, 8'hF0, 1, 1);
      check_eq("mid_reset", 32'({pending, out_valid, code}), 32'h0);
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0, 8'h00, 1, 1);
         check_eq("mid_quiet", 32'(out_valid), 32'h0);
      end

      // random traffic
      for (int i = 0; i < 600; i++) begin
         logic [N-1:0] r;
         r = N'($urandom) & N'($urandom);
         cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0), r,
               1'($urandom), ($urandom_range(0, 3) != 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
